cache_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the shared 16-bit cache that sits behind the processor/cache multiplexer. It accepts request/acknowledge handshakes from proc1 and proc2 and grants the cache to one of them in round-robin order. It drives the multiplexer `sel` and holds it stable for the whole access. It gates the multiplexed write-enable so the cache only sees writes during a granted access window.

---
 rtl/cache_arbiter.sv | 134 +++++++++++++
 tb/tb_cache_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin two-requester arbiter and access sequencer for the shared cache
module cache_arbiter #(
    parameter int CACHE_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic proc1_Req,
    input  logic proc2_Req,
    input  logic mux_WE,
    output logic sel,
    output logic proc1_Gnt,
    output logic proc2_Gnt,
    output logic proc1_Ack,
    output logic proc2_Ack,
    output logic cache_En,
    output logic cache_WE,
    output logic busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Counter reload: ACCESS lasts CACHE_LAT cycles, counting down to zero.
    localparam logic [3:0] LAT_M1 = 4'(CACHE_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_sel;
    logic       w_sel_nxt;
    logic       r_gnt1;
    logic       w_gnt1_nxt;
    logic       r_gnt2;
    logic       w_gnt2_nxt;
    logic       r_ack1;
    logic       w_ack1_nxt;
    logic       r_ack2;
    logic       w_ack2_nxt;
    logic       r_en;
    logic       w_en_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_prio;
    logic       w_prio_nxt;
    logic       w_owner;

    // State and registered outputs; reset abandons any access without an Ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_gnt1  <= 1'b0;
            r_gnt2  <= 1'b0;
            r_ack1  <= 1'b0;
            r_ack2  <= 1'b0;
            r_en    <= 1'b0;
            r_cnt   <= 4'd0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_gnt2  <= w_gnt2_nxt;
            r_ack1  <= w_ack1_nxt;
            r_ack2  <= w_ack2_nxt;
            r_en    <= w_en_nxt;
            r_cnt   <= w_cnt_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a transition changes it.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_gnt1_nxt  = r_gnt1;
        w_gnt2_nxt  = r_gnt2;
        w_ack1_nxt  = 1'b0;
        w_ack2_nxt  = 1'b0;
        w_en_nxt    = r_en;
        w_cnt_nxt   = r_cnt;
        w_prio_nxt  = r_prio;
        w_owner     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (proc1_Req || proc2_Req) begin
                    // Contention is settled by prio; a lone request wins outright.
                    w_owner     = (proc1_Req && proc2_Req) ? r_prio : proc2_Req;
                    w_sel_nxt   = w_owner;
                    w_gnt1_nxt  = ~w_owner;
                    w_gnt2_nxt  = w_owner;
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_DONE;
                    w_en_nxt    = 1'b0;
                    w_ack1_nxt  = r_gnt1;
                    w_ack2_nxt  = r_gnt2;
                    // The requester just served loses priority for the next contention.
                    w_prio_nxt  = ~r_sel;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gnt1_nxt  = 1'b0;
                w_gnt2_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt1_nxt  = 1'b0;
                w_gnt2_nxt  = 1'b0;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    assign sel       = r_sel;
    assign proc1_Gnt = r_gnt1;
    assign proc2_Gnt = r_gnt2;
    assign proc1_Ack = r_ack1;
    assign proc2_Ack = r_ack2;
    assign cache_En  = r_en;
    assign cache_WE  = mux_WE & r_en;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - randomized model-checked bench for cache_arbiter at CACHE_LAT 2, 1 and 15
module tb_cache_arbiter;

    localparam int NDUT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NDUT-1:0] req1;
    logic [NDUT-1:0] req2;
    logic [NDUT-1:0] mwe;
    logic [NDUT-1:0] o_sel;
    logic [NDUT-1:0] o_g1;
    logic [NDUT-1:0] o_g2;
    logic [NDUT-1:0] o_a1;
    logic [NDUT-1:0] o_a2;
    logic [NDUT-1:0] o_en;
    logic [NDUT-1:0] o_we;
    logic [NDUT-1:0] o_busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Transaction-level model: an access is a timeline t = 0..lat after the granting edge.
    bit m_busy  [NDUT];
    int m_t     [NDUT];
    bit m_owner [NDUT];
    bit m_prio  [NDUT];
    bit m_sel   [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        cache_arbiter #(.CACHE_LAT((g == 0) ? 2 : (g == 1) ? 1 : 15)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .proc1_Req (req1[g]),
            .proc2_Req (req2[g]),
            .mux_WE    (mwe[g]),
            .sel       (o_sel[g]),
            .proc1_Gnt (o_g1[g]),
            .proc2_Gnt (o_g2[g]),
            .proc1_Ack (o_a1[g]),
            .proc2_Ack (o_a2[g]),
            .cache_En  (o_en[g]),
            .cache_WE  (o_we[g]),
            .busy      (o_busy[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    // Expected {sel, gnt1, gnt2, ack1, ack2, en, we, busy}
    function automatic logic [7:0] exp_vec(input int k);
        logic g1, g2, a1, a2, en;
        int   lat;
        lat = lat_of(k);
        g1  = m_busy[k] && !m_owner[k];
        g2  = m_busy[k] && m_owner[k];
        en  = m_busy[k] && (m_t[k] < lat);
        a1  = g1 && (m_t[k] == lat);
        a2  = g2 && (m_t[k] == lat);
        return {m_sel[k], g1, g2, a1, a2, en, en & mwe[k], m_busy[k]};
    endfunction

    function automatic logic [7:0] dut_vec(input int k);
        return {o_sel[k], o_g1[k], o_g2[k], o_a1[k], o_a2[k], o_en[k], o_we[k], o_busy[k]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got={sel,g1,g2,a1,a2,en,we,busy}=%b expected=%b t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_busy[k]  = 1'b0;
            m_t[k]     = 0;
            m_owner[k] = 1'b0;
            m_prio[k]  = 1'b0;
            m_sel[k]   = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("dut%0d_%s", k, tag), dut_vec(k), exp_vec(k));
    endtask

    // mode 0: random requesters obeying the handshake, 1: both held, 2: proc2 only held
    task automatic run_cycle(input int mode, input string tag);
        logic [7:0] e;
        for (int k = 0; k < NDUT; k++) begin
            e = exp_vec(k);
            if (mode == 1) begin
                req1[k] = 1'b1; req2[k] = 1'b1; mwe[k] = 1'b1;
            end else if (mode == 2) begin
                req1[k] = 1'b0; req2[k] = 1'b1; mwe[k] = 1'b1;
            end else begin
                mwe[k] = 1'($urandom);
                if (req1[k]) begin
                    if (e[4] || (e[6] && ($urandom % 8 == 0))) req1[k] = 1'b0;
                end else if (!e[6] && ($urandom % 3 == 0)) begin
                    req1[k] = 1'b1;
                end
                if (req2[k]) begin
                    if (e[3] || (e[5] && ($urandom % 8 == 0))) req2[k] = 1'b0;
                end else if (!e[5] && ($urandom % 3 == 0)) begin
                    req2[k] = 1'b1;
                end
            end
            // Advance the model across the coming rising edge.
            if (m_busy[k]) begin
                if (m_t[k] == lat_of(k)) begin
                    m_busy[k] = 1'b0;
                    m_prio[k] = ~m_owner[k];
                end else begin
                    m_t[k]++;
                end
            end else if (req1[k] || req2[k]) begin
                m_owner[k] = (req1[k] && req2[k]) ? m_prio[k] : req2[k];
                m_sel[k]   = m_owner[k];
                m_busy[k]  = 1'b1;
                m_t[k]     = 0;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst  = 1'b1;
        req1 = '0;
        req2 = '0;
        mwe  = '1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // proc2 alone takes the cache, then reset lands mid-access
        run_cycle(2, "p2_grant");
        run_cycle(2, "p2_access");
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("dut%0d_async_rst", k), dut_vec(k), 8'b0);
        model_reset();
        @(negedge clk);
        chk("dut0_rst_held", dut_vec(0), 8'b0);
        rst = 1'b0;

        // Continuous contention: proc1 first after reset, then strict alternation
        for (int i = 0; i < 80; i++) run_cycle(1, "both_held");

        // Randomized traffic including mid-access request drops and WE toggling
        for (int i = 0; i < 3000; i++) run_cycle(0, "random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
